// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - framed byte-stream loader for the instruction RAM write port.
// Optional trailing checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int MEM_WORDS = 201
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int IDX_W = $clog2(MEM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_FINISH,
    S_ERROR
  } state_t;

  // State entered once the header or payload is exhausted.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_FINISH;
`endif

  state_t           state;
  state_t           state_nx;
  logic [7:0]       hdr_lo;
  logic [15:0]      n_words;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      asm_buf;
  logic             accept;
  logic [15:0]      hdr_n;
  logic             last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  always_comb begin
    byte_ready = 1'b0;
    case (state)
      S_HDR_LO, S_HDR_HI, S_DATA: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                     byte_ready = 1'b1;
`endif
      default:                    byte_ready = 1'b0;
    endcase
  end

  // A handshake coinciding with load_start belongs to the aborted frame.
  assign accept    = byte_valid && byte_ready && !load_start;
  assign hdr_n     = {byte_data, hdr_lo};
  assign last_word = (({{(16-IDX_W){1'b0}}, word_idx} + 16'd1) == n_words);
  assign busy      = (state != S_IDLE) && (state != S_ERROR);
  assign err       = (state == S_ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (load_start) state_nx = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (accept) state_nx = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (accept) begin
          if (hdr_n == 16'd0)                 state_nx = S_TAIL;
          else if (hdr_n > 16'(MEM_WORDS))    state_nx = S_ERROR;
          else                                state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (byte_cnt == 2'd3) && last_word) state_nx = S_TAIL;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_nx = (byte_data == csum) ? S_FINISH : S_ERROR;
      end
`endif
      S_FINISH: state_nx = S_IDLE;
      S_ERROR:  state_nx = S_ERROR;
      default:  state_nx = S_IDLE;
    endcase
    if (load_start) state_nx = S_HDR_LO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= 32'd0;
      wr_data  <= 32'd0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      hdr_lo   <= 8'd0;
      n_words  <= 16'd0;
      word_idx <= '0;
      byte_cnt <= 2'd0;
      asm_buf  <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= (state == S_FINISH) && !load_start;
      // Hold is released on the edge where the done pulse ends.
      if (load_start)  cpu_hold <= 1'b1;
      else if (done)   cpu_hold <= 1'b0;

      if (load_start) begin
        word_idx <= '0;
        byte_cnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
        csum     <= 8'd0;
`endif
      end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
        csum <= csum + byte_data;
`endif
        case (state)
          S_HDR_LO: hdr_lo  <= byte_data;
          S_HDR_HI: n_words <= hdr_n;
          S_DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= {{(30-IDX_W){1'b0}}, word_idx, 2'b00};
              wr_data  <= {byte_data, asm_buf};
              word_idx <= word_idx + 1'b1;
            end else begin
              asm_buf[{byte_cnt, 3'b000} +: 8] <= byte_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed scoreboard bench for instr_loader.
module tb_instr_loader;

  localparam int MEM_WORDS = 201;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          d0;
  logic [63:0] exp_q[$];
  logic [31:0] words[$];
  logic [63:0] mon_e;

  always #5 clk = ~clk;

  instr_loader #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (wr_en) begin
        chk("wr_pending", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", wr_addr, mon_e[63:32]);
          chk("wr_data", wr_data, mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      ok = byte_ready;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (!ok) chk("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_frame(input int gap, input bit bad_csum);
    logic [15:0] n;
    logic [7:0]  sum;
    logic [7:0]  b;
    n   = 16'(words.size());
    sum = n[7:0] + n[15:8];
    send_byte(n[7:0], 0);
    send_byte(n[15:8], gap);
    for (int i = 0; i < words.size(); i++) begin
      for (int j = 0; j < 4; j++) begin
        b   = words[i][8*j +: 8];
        sum = sum + b;
        if (j == 3) exp_q.push_back({32'(i * 4), words[i]});
        send_byte(b, gap);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_csum ? sum + 8'd1 : sum, gap);
`else
    if (bad_csum) chk("csum_unsupported", 32'd0, 32'd1);
`endif
  endtask

  task automatic expect_done();
    chk("done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("hold_during_done", {31'd0, cpu_hold}, 32'd1);
    @(negedge clk);
    chk("done_end", {31'd0, done}, 32'd0);
    chk("hold_released", {31'd0, cpu_hold}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state, before any clock edge.
    #1;
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word load.
    words = '{32'h006102E7, 32'h008002EF};
    d0 = done_cnt;
    pulse_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_hold", {31'd0, cpu_hold}, 32'd1);
    chk("start_ready", {31'd0, byte_ready}, 32'd1);
    send_frame(0, 1'b0);
    expect_done();
    repeat (3) @(negedge clk);
    chk("basic_done_once", done_cnt - d0, 32'd1);
    chk("basic_q_empty", exp_q.size(), 32'd0);

    // Same frame under backpressure.
    d0 = done_cnt;
    pulse_start();
    send_frame(2, 1'b0);
    expect_done();
    repeat (3) @(negedge clk);
    chk("bp_done_once", done_cnt - d0, 32'd1);
    chk("bp_q_empty", exp_q.size(), 32'd0);

    // Oversize header.
    pulse_start();
    send_byte(8'd202, 0);
    send_byte(8'd0, 0);
    chk("ovr_err", {31'd0, err}, 32'd1);
    chk("ovr_ready", {31'd0, byte_ready}, 32'd0);
    chk("ovr_busy", {31'd0, busy}, 32'd0);
    chk("ovr_hold", {31'd0, cpu_hold}, 32'd1);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    chk("ovr_err_sticky", {31'd0, err}, 32'd1);
    pulse_start();
    chk("ovr_err_clear", {31'd0, err}, 32'd0);
    chk("ovr_restart_busy", {31'd0, busy}, 32'd1);

    // Largest legal image, on the load just started.
    words.delete();
    for (int i = 0; i < MEM_WORDS; i++) words.push_back($urandom);
    send_frame(0, 1'b0);
    expect_done();
    chk("full_q_empty", exp_q.size(), 32'd0);

    // Empty image.
    words.delete();
    d0 = done_cnt;
    pulse_start();
    send_frame(0, 1'b0);
    expect_done();
    repeat (2) @(negedge clk);
    chk("n0_done_once", done_cnt - d0, 32'd1);

    // Abort after five payload bytes, offering a byte in the restart cycle.
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    send_byte(8'h22, 0);
    exp_q.push_back({32'h0, 32'h11223344});
    send_byte(8'h11, 0);
    send_byte(8'hAA, 0);
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hBB;
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b0;
    chk("rs_busy", {31'd0, busy}, 32'd1);
    chk("rs_ready", {31'd0, byte_ready}, 32'd1);
    words = '{32'h00A10113};
    send_frame(0, 1'b0);
    expect_done();
    chk("rs_q_empty", exp_q.size(), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: payload still written, then error with CPU held.
    d0 = done_cnt;
    pulse_start();
    send_frame(0, 1'b1);
    chk("cs_err", {31'd0, err}, 32'd1);
    chk("cs_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (3) @(negedge clk);
    chk("cs_no_done", done_cnt - d0, 32'd0);
    chk("cs_hold_stays", {31'd0, cpu_hold}, 32'd1);
    chk("cs_q_empty", exp_q.size(), 32'd0);
`endif

    // Asynchronous reset in the middle of a frame.
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    exp_q.push_back({32'h0, 32'h12345678});
    send_byte(8'h12, 0);
    send_byte(8'h99, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, byte_ready}, 32'd0);
    chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("arst_wr_addr", wr_addr, 32'd0);
    chk("arst_wr_data", wr_data, 32'd0);
    chk("arst_hold", {31'd0, cpu_hold}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_q_empty", exp_q.size(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
